xor_parity_acc: RTL and testbench

- Parametrised, clocked successor to the team's switch-level XOR gate: a streaming XOR accumulator over multi-bit words.
- Folds a fixed-length frame of WIDTH-bit words into two results:
  - a column-wise XOR vector;
  - a single frame parity bit, with optional odd-parity sense and a check mode that flags mismatches.
- Sits between a word source and a consumer.
- Uses a valid/ready handshake on both sides.

---
 rtl/xor_parity_acc.sv | 146 ++++++++++++++
 tb/tb_xor_parity_acc.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/xor_parity_acc.sv
// Streaming XOR accumulator: folds FRAME_LEN words of WIDTH bits into a column-wise
// XOR vector and a frame parity bit, with an optional parity check mode.
module xor_parity_acc #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4,
  parameter bit ODD       = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  input  logic             in_par,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_cols,
  output logic             out_parity,
  output logic             out_err
);

  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  function automatic logic word_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction

  state_t            state_r, state_s;
  logic [CW-1:0]     count_r, count_s;
  logic [WIDTH-1:0]  col_r, col_s;
  logic              bp_r, bp_s;
  logic              mode_r, mode_s;
  logic [WIDTH-1:0]  cols_r, cols_s;
  logic              par_r, par_s;
  logic              err_r, err_s;
  logic              in_ready_r;
  logic              out_valid_r;
  logic              accept_s;
  logic              frame_mode_s;
  logic              frame_par_s;

  assign accept_s = in_valid & in_ready_r;

  // Next-state and accumulator update; clr overrides accept and out_ready.
  always_comb begin
    state_s      = state_r;
    count_s      = count_r;
    col_s        = col_r;
    bp_s         = bp_r;
    mode_s       = mode_r;
    cols_s       = cols_r;
    par_s        = par_r;
    err_s        = err_r;
    frame_mode_s = (count_r == {CW{1'b0}}) ? in_mode : mode_r;
    frame_par_s  = bp_r ^ word_parity(in_data) ^ ODD;
    if (clr) begin
      state_s = ACC;
      count_s = {CW{1'b0}};
      col_s   = {WIDTH{1'b0}};
      bp_s    = 1'b0;
      mode_s  = 1'b0;
      cols_s  = {WIDTH{1'b0}};
      par_s   = 1'b0;
      err_s   = 1'b0;
    end else begin
      case (state_r)
        ACC: begin
          if (accept_s) begin
            if (count_r == LAST_IDX) begin
              state_s = DONE;
              cols_s  = col_r ^ in_data;
              par_s   = frame_par_s;
              err_s   = frame_mode_s & (frame_par_s != in_par);
              count_s = {CW{1'b0}};
              col_s   = {WIDTH{1'b0}};
              bp_s    = 1'b0;
              mode_s  = 1'b0;
            end else begin
              count_s = count_r + CW'(1);
              col_s   = col_r ^ in_data;
              bp_s    = bp_r ^ word_parity(in_data);
              mode_s  = frame_mode_s;
            end
          end else begin
            state_s = ACC;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_s = ACC;
          end else begin
            state_s = DONE;
          end
        end
        default: begin
          state_s = ACC;
          count_s = {CW{1'b0}};
          col_s   = {WIDTH{1'b0}};
          bp_s    = 1'b0;
          mode_s  = 1'b0;
        end
      endcase
    end
  end

  // State, accumulator and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ACC;
      count_r     <= {CW{1'b0}};
      col_r       <= {WIDTH{1'b0}};
      bp_r        <= 1'b0;
      mode_r      <= 1'b0;
      cols_r      <= {WIDTH{1'b0}};
      par_r       <= 1'b0;
      err_r       <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      count_r     <= count_s;
      col_r       <= col_s;
      bp_r        <= bp_s;
      mode_r      <= mode_s;
      cols_r      <= cols_s;
      par_r       <= par_s;
      err_r       <= err_s;
      in_ready_r  <= (state_s == ACC);
      out_valid_r <= (state_s == DONE);
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_cols   = cols_r;
  assign out_parity = par_r;
  assign out_err    = err_r;

endmodule

// File: tb/tb_xor_parity_acc.sv
// Directed bench for xor_parity_acc: default 8x4 even-parity instance plus an
// odd-parity single-word-frame instance.
module tb_xor_parity_acc;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_mode;
  logic       in_par;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_cols;
  logic       out_parity;
  logic       out_err;

  logic       b_clr;
  logic       b_in_valid;
  logic       b_in_ready;
  logic [7:0] b_in_data;
  logic       b_in_mode;
  logic       b_in_par;
  logic       b_out_valid;
  logic       b_out_ready;
  logic [7:0] b_out_cols;
  logic       b_out_parity;
  logic       b_out_err;

  int checks;
  int failures;

  xor_parity_acc #(.WIDTH(8), .FRAME_LEN(4), .ODD(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_par(in_par),
    .out_valid(out_valid), .out_ready(out_ready), .out_cols(out_cols),
    .out_parity(out_parity), .out_err(out_err)
  );

  xor_parity_acc #(.WIDTH(8), .FRAME_LEN(1), .ODD(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(b_clr),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_mode(b_in_mode), .in_par(b_in_par),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_cols(b_out_cols),
    .out_parity(b_out_parity), .out_err(b_out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Offer one word to dut_a for one edge; called and returns at posedge+1.
  task automatic push(input logic [7:0] d, input logic m, input logic p);
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    in_par   = p;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_mode  = 1'b0;
    in_par   = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    in_mode = 1'b0; in_par = 1'b0; out_ready = 1'b1;
    b_clr = 1'b0; b_in_valid = 1'b0; b_in_data = 8'h00;
    b_in_mode = 1'b0; b_in_par = 1'b0; b_out_ready = 1'b1;

    #12;
    check("rst_valid",  {31'd0, out_valid},  32'd0);
    check("rst_cols",   {24'd0, out_cols},   32'd0);
    check("rst_parity", {31'd0, out_parity}, 32'd0);
    check("rst_err",    {31'd0, out_err},    32'd0);
    @(negedge clk); rst_n = 1'b1;
    idle_cycle();
    check("rst_ready", {31'd0, in_ready}, 32'd1);

    // 1: generate mode, back-to-back
    push(8'h01, 1'b0, 1'b0); push(8'h02, 1'b0, 1'b0); push(8'h04, 1'b0, 1'b0);
    check("t1_mid_valid", {31'd0, out_valid}, 32'd0);
    push(8'h08, 1'b0, 1'b0);
    check("t1_valid",  {31'd0, out_valid},  32'd1);
    check("t1_cols",   {24'd0, out_cols},   32'h0F);
    check("t1_parity", {31'd0, out_parity}, 32'd0);
    check("t1_err",    {31'd0, out_err},    32'd0);
    check("t1_ready",  {31'd0, in_ready},   32'd0);
    idle_cycle();

    // 2: check mode, mismatching then matching expected parity
    push(8'h01, 1'b1, 1'b0); push(8'h02, 1'b0, 1'b0); push(8'h04, 1'b0, 1'b0);
    push(8'h08, 1'b0, 1'b1);
    check("t2a_parity", {31'd0, out_parity}, 32'd0);
    check("t2a_err",    {31'd0, out_err},    32'd1);
    idle_cycle();
    push(8'h01, 1'b1, 1'b0); push(8'h02, 1'b0, 1'b0); push(8'h04, 1'b0, 1'b0);
    push(8'h08, 1'b0, 1'b0);
    check("t2b_err", {31'd0, out_err}, 32'd0);
    idle_cycle();

    // 3: backpressure holds DONE; a word offered meanwhile is ignored
    push(8'h03, 1'b0, 1'b0); push(8'h00, 1'b0, 1'b0); push(8'h00, 1'b0, 1'b0);
    out_ready = 1'b0;
    push(8'h01, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      check("t3_hold_valid",  {31'd0, out_valid},  32'd1);
      check("t3_hold_cols",   {24'd0, out_cols},   32'h02);
      check("t3_hold_parity", {31'd0, out_parity}, 32'd1);
      check("t3_hold_ready",  {31'd0, in_ready},   32'd0);
      idle_cycle();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle_cycle();
    check("t3_rel_valid", {31'd0, out_valid}, 32'd0);
    check("t3_rel_ready", {31'd0, in_ready},  32'd1);
    push(8'h01, 1'b0, 1'b0); push(8'h02, 1'b0, 1'b0); push(8'h04, 1'b0, 1'b0);
    check("t3_next_mid", {31'd0, out_valid}, 32'd0);
    push(8'h08, 1'b0, 1'b0);
    check("t3_next_cols", {24'd0, out_cols}, 32'h0F);
    idle_cycle();

    // 4: asynchronous reset mid-frame
    push(8'hFF, 1'b0, 1'b0); push(8'h01, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t4_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t4_rst_cols",  {24'd0, out_cols},  32'd0);
    @(negedge clk); rst_n = 1'b1;
    idle_cycle();
    check("t4_ready", {31'd0, in_ready}, 32'd1);
    push(8'h10, 1'b0, 1'b0); push(8'h20, 1'b0, 1'b0);
    check("t4_mid_valid", {31'd0, out_valid}, 32'd0);
    push(8'h40, 1'b0, 1'b0); push(8'h80, 1'b0, 1'b0);
    check("t4_valid",  {31'd0, out_valid},  32'd1);
    check("t4_cols",   {24'd0, out_cols},   32'hF0);
    check("t4_parity", {31'd0, out_parity}, 32'd0);
    idle_cycle();

    // 5: clr beats a simultaneous accept; next frame has a gap
    push(8'hAA, 1'b0, 1'b0); push(8'h55, 1'b0, 1'b0);
    clr = 1'b1;
    push(8'h0F, 1'b0, 1'b0);
    clr = 1'b0;
    check("t5_clr_valid", {31'd0, out_valid}, 32'd0);
    check("t5_clr_ready", {31'd0, in_ready},  32'd1);
    push(8'h01, 1'b0, 1'b0); push(8'h00, 1'b0, 1'b0);
    idle_cycle();
    push(8'h00, 1'b0, 1'b0);
    check("t5_gap_valid", {31'd0, out_valid}, 32'd0);
    push(8'h00, 1'b0, 1'b0);
    check("t5_valid",  {31'd0, out_valid},  32'd1);
    check("t5_cols",   {24'd0, out_cols},   32'h01);
    check("t5_parity", {31'd0, out_parity}, 32'd1);
    idle_cycle();

    // 6: odd parity, single-word frames, check mode
    b_in_valid = 1'b1; b_in_data = 8'h07; b_in_mode = 1'b1; b_in_par = 1'b0;
    idle_cycle();
    b_in_valid = 1'b0;
    check("t6a_valid",  {31'd0, b_out_valid},  32'd1);
    check("t6a_cols",   {24'd0, b_out_cols},   32'h07);
    check("t6a_parity", {31'd0, b_out_parity}, 32'd0);
    check("t6a_err",    {31'd0, b_out_err},    32'd0);
    idle_cycle();
    b_in_valid = 1'b1; b_in_data = 8'h06; b_in_mode = 1'b1; b_in_par = 1'b0;
    idle_cycle();
    b_in_valid = 1'b0;
    check("t6b_cols",   {24'd0, b_out_cols},   32'h06);
    check("t6b_parity", {31'd0, b_out_parity}, 32'd1);
    check("t6b_err",    {31'd0, b_out_err},    32'd1);
    idle_cycle();
    check("t6_release", {31'd0, b_out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
